// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1-style UART receiver, mid-bit sampling, single-entry output
//            register with valid/ready handshake, overrun and frame-error pulses.
// Revision : 1.0
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rxd,
  output logic [DATA_WIDTH-1:0] o_data_m,
  output logic                  o_valid_m,
  input  logic                  i_ready_m,
  output logic                  o_busy,
  output logic                  o_overrun_error,
  output logic                  o_frame_error
);

  localparam int c_DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int c_HALF = c_DIV / 2;
  localparam int c_CW   = $clog2(c_DIV + 1);
  localparam int c_BW   = $clog2(DATA_WIDTH + 1);

  localparam logic [c_CW-1:0] c_DIV_V  = c_CW'(c_DIV);
  localparam logic [c_CW-1:0] c_HALF_V = c_CW'(c_HALF);
  localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);
  localparam logic [c_BW-1:0] c_LAST   = c_BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_sync1;
  logic                    r_sync2;
  logic [c_CW-1:0]         r_cnt;
  logic [c_CW-1:0]         w_cnt_nxt;
  logic [c_BW-1:0]         r_bitcnt;
  logic [c_BW-1:0]         w_bitcnt_nxt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [DATA_WIDTH-1:0]   w_shift_nxt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    r_ovr;
  logic                    r_ferr;
  logic                    w_rxd;
  logic                    w_tick;
  logic                    w_deliver;
  logic                    w_ferr;

  assign w_rxd  = r_sync2;
  assign w_tick = (r_cnt == c_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_sync1  <= i_rxd;
      r_sync2  <= r_sync1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_deliver    = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxd) begin
          w_state_nxt  = S_START;
          w_cnt_nxt    = c_HALF_V;
          w_bitcnt_nxt = '0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_cnt_nxt   = c_DIV_V;
          w_state_nxt = w_rxd ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = c_DIV_V;
          w_shift_nxt = {w_rxd, r_shift[DATA_WIDTH-1:1]};
          if (r_bitcnt == c_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (w_rxd) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      // A held-low line (break) must go high before another start is accepted.
      S_WAIT_HIGH: begin
        if (w_rxd) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Single-entry output slot; a delivery into an occupied, unconsumed slot is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ovr  <= 1'b0;
      r_ferr <= w_ferr;
      if (w_deliver) begin
        if (r_valid && !i_ready_m) begin
          r_ovr <= 1'b1;
        end else begin
          r_data  <= w_shift_nxt;
          r_valid <= 1'b1;
        end
      end else if (r_valid && i_ready_m) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data_m        = r_data;
  assign o_valid_m       = r_valid;
  assign o_busy          = (r_state != S_IDLE);
  assign o_overrun_error = r_ovr;
  assign o_frame_error   = r_ferr;

endmodule
`default_nettype wire
